// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding, default operand width and op codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the bit-serial arithmetic units.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b (LSB first) through one full_adder cell with a start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_ADD_MODE_EN to add the op port (op=1 subtract, op=0 add).
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic start_ok;
  logic last_bit;
  logic sub_mode;
  logic start_sub;
  logic fa_b, fa_s, fa_cout;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic sub_q, sub_d;
  assign sub_mode  = sub_q;
  assign start_sub = (op == OP_SUB);
`else
  assign sub_mode  = 1'b1;
  assign start_sub = 1'b1;
`endif

  assign start_ok = start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_CNT);

  // Subtraction is a + ~b + 1: invert b into the cell, carry preloaded to 1.
  assign fa_b = sub_mode ? ~b_sr_q[0] : b_sr_q[0];

  full_adder u_cell (
    .a    (a_sr_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    sub_d    = sub_q;
`endif
    if (start_ok) begin
      a_sr_d   = a;
      b_sr_d   = b;
      res_sr_d = '0;
      cnt_d    = '0;
      carry_d  = start_sub;
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_d    = start_sub;
`endif
    end else if (state_q == RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
      carry_d  = fa_cout;
      cnt_d    = cnt_q + CNT_W'(1);
      // Visible results change only here, so they hold through a following run.
      if (last_bit) begin
        diff_d   = {fa_s, res_sr_q[WIDTH-1:1]};
        borrow_d = sub_mode ? ~fa_cout : fa_cout;
        ovf_d    = sub_mode ? ((a_msb_q != b_msb_q) && (fa_s != a_msb_q))
                            : ((a_msb_q == b_msb_q) && (fa_s != a_msb_q));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_q    <= OP_SUB;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .op       (1'b1),
`endif
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r = r + (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = (int'(x) >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
    sy = (int'(y) >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // Launches one operation and observes it up to the done pulse (or a 20-cycle bound).
  // lat is the number of edges from the accepting edge to done; -1 on timeout.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] d, output logic bo, output logic ov,
                       output int lat, output int busy_bad, output int held_bad);
    logic [W-1:0] d0;
    logic         bo0, ov0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    d0 = diff; bo0 = borrow; ov0 = overflow;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = -1; busy_bad = 0; held_bad = 0;
    d = 'x; bo = 1'bx; ov = 1'bx;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        lat = k;
        d = diff; bo = borrow; ov = overflow;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (diff !== d0 || borrow !== bo0 || overflow !== ov0) held_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, borrow, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy, done, diff, borrow, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F, 8'hFF};
    logic [W-1:0] tb [6] = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h01};
    logic [W-1:0] ed [6] = '{8'h02, 8'hFE, 8'h7F, 8'h00, 8'h80, 8'hFE};
    logic         eb [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bb, hb;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], d, bo, ov, lat, bb, hb);
      checks++;
      if (lat !== W) begin
        failures++;
        $display("FAIL dir%0d_latency: got %0d, want %0d", i, lat, W);
      end
      checks++;
      if (bb !== 0) begin
        failures++;
        $display("FAIL dir%0d_busy: %0d cycles with wrong busy, want 0", i, bb);
      end
      checks++;
      if (d !== ed[i] || bo !== eb[i] || ov !== eo[i]) begin
        failures++;
        $display("FAIL dir%0d_result a=%h b=%h: got diff=%h borrow=%b ovf=%b, want %h %b %b",
                 i, ta[i], tb[i], d, bo, ov, ed[i], eb[i], eo[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || diff !== ed[i]) begin
        failures++;
        $display("FAIL dir%0d_after: got done=%b diff=%h, want 0 %h", i, done, diff, ed[i]);
      end
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, d;
    logic bo, ov;
    int lat, bb, hb;
    for (int i = 0; i < 40; i++) begin
      av = W'($urandom); bv = W'($urandom);
      if (i % 7 == 0) bv = av;
      do_op(av, bv, d, bo, ov, lat, bb, hb);
      checks++;
      if (lat !== W || bb !== 0 || hb !== 0 || d !== ref_diff(av, bv) ||
          bo !== ref_borrow(av, bv) || ov !== ref_ovf(av, bv)) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h: got lat=%0d busybad=%0d heldbad=%0d diff=%h borrow=%b ovf=%b, want lat=%0d diff=%h borrow=%b ovf=%b",
                 i, av, bv, lat, bb, hb, d, bo, ov, W, ref_diff(av, bv), ref_borrow(av, bv), ref_ovf(av, bv));
      end
      if (i % 3 == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int dones, first;
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; first = -1;
    for (int k = 0; k < 14; k++) begin
      if (k == 3) begin a = 8'h09; b = 8'h01; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first < 0) begin
          first = k;
          checks++;
          if (diff !== 8'h02 || borrow !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: got diff=%h borrow=%b ovf=%b, want 02 0 0", diff, borrow, overflow);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 1 || first !== W) begin
      failures++;
      $display("FAIL ignore_pulses: got %0d done pulses first at %0d, want 1 at %0d", dones, first, W);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bb, hb;
    repeat (2) @(posedge clk);
    do_op(8'h05, 8'h03, d, bo, ov, lat, bb, hb);
    checks++;
    if (lat !== W || d !== 8'h02) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d diff=%h, want %0d 02", lat, d, W);
    end
    // Called straight from the done cycle, so start is high in DONE.
    do_op(8'h10, 8'h20, d, bo, ov, lat, bb, hb);
    checks++;
    if (lat !== W || bb !== 0) begin
      failures++;
      $display("FAIL b2b_timing: got lat=%0d busybad=%0d, want %0d 0", lat, bb, W);
    end
    checks++;
    if (hb !== 0) begin
      failures++;
      $display("FAIL b2b_hold: first result changed in %0d cycles, want 0", hb);
    end
    checks++;
    if (d !== 8'hF0 || bo !== 1'b1 || ov !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got diff=%h borrow=%b ovf=%b, want f0 1 0", d, bo, ov);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] d;
    logic bo, ov;
    int lat, bb, hb, dones;
    repeat (2) @(posedge clk);
    do_op(8'h7F, 8'hFF, d, bo, ov, lat, bb, hb);
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow, overflow} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
               busy, done, diff, borrow, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d cycles with busy/done after abort, want 0", dones);
    end
    do_op(8'h80, 8'h01, d, bo, ov, lat, bb, hb);
    checks++;
    if (lat !== W || d !== 8'h7F || bo !== 1'b0 || ov !== 1'b1) begin
      failures++;
      $display("FAIL abort_recover: got lat=%0d diff=%h borrow=%b ovf=%b, want %0d 7f 0 1", lat, d, bo, ov, W);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
